// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - encodings, opcodes and state codes for the multi-cycle MIPS controller
package multicycle_ctrl_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGNED = 2'b01;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DCD    = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_WB_ALU = 4'd4,
    S_MADR   = 4'd5,
    S_MRD    = 4'd6,
    S_WB_MEM = 4'd7,
    S_MWR    = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10
  } state_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU) ||
           (funct == FUNCT_AND)  || (funct == FUNCT_OR);
  endfunction

  function automatic logic instr_supported(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    case (op)
      OP_RTYPE:                        ok = funct_supported(funct);
      OP_ADDIU, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_J:                    ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// rtl/multicycle_ctrl_alu_dec.sv - combinational Op/Funct to ALU operation and immediate extension mode
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op
);

  always_comb begin
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_SUBU: alu_op = ALU_SUB;
          FUNCT_AND:  alu_op = ALU_AND;
          FUNCT_OR:   alu_op = ALU_OR;
          default:    alu_op = ALU_ADD;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        alu_op = ALU_ADD;
        ext_op = EXT_SIGNED;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        ext_op = EXT_ZERO;
      end
      // beq compares by subtraction; the branch offset is extended inside the NPC unit
      OP_BEQ:  alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main controller driving all datapath control inputs
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] EXTOp,
  output logic       BSel,
  output logic       WRSel,
  output logic       WDSel,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  logic [1:0] dec_alu;
  logic [1:0] dec_ext;

  multicycle_ctrl_alu_dec u_alu_dec (
    .op     (Op),
    .funct  (Funct),
    .alu_op (dec_alu),
    .ext_op (dec_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DCD;
      S_DCD: begin
        if (!instr_supported(Op, Funct)) state_next = S_FETCH;
        else begin
          case (Op)
            OP_RTYPE:         state_next = S_EXE_R;
            OP_ADDIU, OP_ORI: state_next = S_EXE_I;
            OP_LW, OP_SW:     state_next = S_MADR;
            OP_BEQ:           state_next = S_BR;
            OP_J:             state_next = S_JMP;
            default:          state_next = S_FETCH;
          endcase
        end
      end
      S_EXE_R, S_EXE_I: state_next = S_WB_ALU;
      S_MADR:           state_next = (Op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:            state_next = S_WB_MEM;
      default:          state_next = S_FETCH;
    endcase
  end

  // Outputs follow state and the held IR fields; reset masks them so no partial write lands
  always_comb begin
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    ALUOp      = ALU_ADD;
    NPCOp      = NPC_PLUS4;
    EXTOp      = EXT_ZERO;
    BSel       = 1'b0;
    WRSel      = 1'b0;
    WDSel      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
          NPCOp = NPC_PLUS4;
        end
        S_DCD: illegal = !instr_supported(Op, Funct);
        S_EXE_R: begin
          BSel  = 1'b0;
          ALUOp = dec_alu;
        end
        S_EXE_I: begin
          BSel  = 1'b1;
          ALUOp = dec_alu;
          EXTOp = dec_ext;
        end
        S_WB_ALU: begin
          RFWr       = 1'b1;
          WDSel      = 1'b0;
          WRSel      = (Op == OP_RTYPE);
          BSel       = (Op != OP_RTYPE);
          ALUOp      = dec_alu;
          EXTOp      = dec_ext;
          instr_done = 1'b1;
        end
        S_MADR, S_MRD: begin
          BSel  = 1'b1;
          ALUOp = ALU_ADD;
          EXTOp = EXT_SIGNED;
        end
        S_WB_MEM: begin
          RFWr       = 1'b1;
          WDSel      = 1'b1;
          WRSel      = 1'b0;
          instr_done = 1'b1;
        end
        S_MWR: begin
          DMWr       = 1'b1;
          BSel       = 1'b1;
          ALUOp      = ALU_ADD;
          EXTOp      = EXT_SIGNED;
          instr_done = 1'b1;
        end
        S_BR: begin
          BSel       = 1'b0;
          ALUOp      = ALU_SUB;
          NPCOp      = NPC_BRANCH;
          PCWr       = Zero;
          instr_done = 1'b1;
        end
        S_JMP: begin
          PCWr       = 1'b1;
          NPCOp      = NPC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main controller for the MIPS core; sits directly upstream of the datapath and drives every datapath control input.
- Consumes Op/Funct from the instruction register and Zero from the ALU.
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, one state per clock.
- Produces PCWr, IRWr, RFWr, DMWr, ALUOp, NPCOp, EXTOp, BSel and the write-back mux selects.

Parameters:
- none. All encodings come from ctrl_encode_def.v.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- Op  in  6  instruction bits 31:26, held by IR
- Funct  in  6  instruction bits 5:0
- Zero  in  1  ALU zero flag
- PCWr  out  1  PC register write enable
- IRWr  out  1  instruction register write enable
- RFWr  out  1  register file write enable
- DMWr  out  1  data memory write enable
- ALUOp  out  2  ALU operation
- NPCOp  out  2  next-PC source
- EXTOp  out  2  immediate extension mode
- BSel  out  1  ALU B input: 0 = RD2, 1 = Imm32
- WRSel  out  1  RF write address: 0 = rt, 1 = rd
- WDSel  out  1  RF write data: 0 = ALU result, 1 = DM_Out
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse when an unsupported Op/Funct is decoded

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk.
- rst high: state <= S_FETCH on the clock edge. While rst is high, all enables (PCWr, IRWr, RFWr, DMWr), instr_done and illegal are forced to 0. ALUOp, NPCOp, EXTOp, BSel, WRSel and WDSel are forced to 00/0.
- rst mid-instruction: abandon the instruction, with no partial RF or DM write in the reset cycle. The first cycle after rst falls is S_FETCH.
- Supported instructions:
  - addu, subu, and, or: Op 000000 with Funct 100001, 100011, 100100, 100101
  - addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, j 000010
- Outputs are Moore style: a function of the state register and the current Op/Funct only. The one exception is PCWr in S_BR, which also depends on Zero.
- States and outputs:
  - S_FETCH: IRWr=1, PCWr=1, NPCOp=NPC_PLUS4. Next state S_DCD.
  - S_DCD: no enables. Next state by Op/Funct:
    - R-type -> S_EXE_R
    - addiu/ori -> S_EXE_I
    - lw/sw -> S_MADR
    - beq -> S_BR
    - j -> S_JMP
    - anything else -> S_FETCH, with illegal=1 in S_DCD.
  - S_EXE_R: BSel=0, ALUOp from Funct (ADD, SUB, AND, OR). Next state S_WB_ALU.
  - S_EXE_I: BSel=1. addiu uses ALU_ADD with EXT_SIGNED; ori uses ALU_OR with EXT_ZERO. Next state S_WB_ALU.
  - S_WB_ALU: RFWr=1, WDSel=0. WRSel=1 for R-type, 0 for I-type. ALU selects are held as in EXE. instr_done=1. Next state S_FETCH.
  - S_MADR: BSel=1, ALU_ADD, EXT_SIGNED. Next state S_MRD for lw, S_MWR for sw.
  - S_MRD: address selects held. Next state S_WB_MEM.
  - S_WB_MEM: RFWr=1, WDSel=1, WRSel=0. instr_done=1. Next state S_FETCH.
  - S_MWR: DMWr=1, address selects held. instr_done=1. Next state S_FETCH.
  - S_BR: BSel=0, ALU_SUB, NPCOp=NPC_BRANCH, PCWr=Zero. instr_done=1. Next state S_FETCH.
    - The PC already holds old PC+4, so the target is PC + (sext(imm) << 2).
  - S_JMP: PCWr=1, NPCOp=NPC_JUMP. instr_done=1. Next state S_FETCH.
- Latency in cycles, FETCH through completion:
  - R-type, addiu, ori, sw: 4
  - lw: 5
  - beq, j: 3
  - illegal: 2
- At most one of RFWr or DMWr is high in any cycle. PCWr is never high in the same cycle as RFWr or DMWr.
- Any unreachable state encoding returns to S_FETCH on the next clock with all enables 0.

Decomposition:
- Add to ctrl_encode_def.v:
  - ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11
  - NPC_PLUS4=00, NPC_BRANCH=01, NPC_JUMP=10
  - EXT_ZERO=00 (EXT_SIGNED already defined)
  - opcode and funct constants
  - 4-bit state codes
- One natural sub-module, alu_dec: combinational Funct/Op to ALUOp/EXTOp. The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles mid-S_MWR of a sw -> DMWr=0 in both cycles; the first cycle after release is S_FETCH with IRWr=1, PCWr=1, NPCOp=00.
- addu (Op 0, Funct 100001) -> IRWr/PCWr in cycle 1, nothing in cycle 2, ALUOp=00 BSel=0 in cycle 3, RFWr=1 WRSel=1 WDSel=0 instr_done=1 in cycle 4.
- lw (Op 100011) -> 5 cycles; BSel=1 ALUOp=00 EXTOp=signed in cycles 3-4; RFWr=1 WDSel=1 WRSel=0 only in cycle 5. sw (101011) -> DMWr=1 only in cycle 4.
- beq, Zero=1 -> cycle 3 has PCWr=1 NPCOp=01 ALUOp=01. Same instruction with Zero=0 -> PCWr=0; next fetch follows at cycle 4.
- ori (001101) -> EXTOp=EXT_ZERO, ALUOp=11, RFWr with WRSel=0 in cycle 4. j (000010) -> PCWr=1 NPCOp=10 in cycle 3.
- Op=111111, or Op=0 with Funct=000000 -> illegal=1 in cycle 2, no RF/DM/PC write, FETCH in cycle 3. Also check at every cycle of a random legal stream: RFWr&DMWr==0 and PCWr&(RFWr|DMWr)==0.
